// File: rtl/input_conditioner_pkg.sv
// Shared constants, the debounce action type and the counter-width helper for input_conditioner.
// Imported by debounce_bit and by the input_conditioner top level.
package input_conditioner_pkg;

  localparam int BTN_EDGE_LSB = 16;
  localparam int MAX_BTN      = 16;
  localparam int MAX_SW       = 32;

  // What the debouncer does to its state on the coming clock edge.
  typedef enum logic [1:0] {
    DB_IDLE,
    DB_COUNT,
    DB_ACCEPT
  } db_action_e;

  // Width needed to hold 0..debounce_cycles; never narrower than one bit.
  function automatic int cnt_width(input int debounce_cycles);
    int w;
    w = $clog2(debounce_cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// One-bit two-flop synchroniser followed by a stable-level debouncer.
// A new level is accepted only after DEBOUNCE_CYCLES consecutive samples that differ from the held level.
module debounce_bit
  import input_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic          stable;
  logic [CW-1:0] cnt;
  db_action_e    action;

  // NOTE: the default is assigned before any branch, so this block can never infer a latch.
  always_comb begin
    action = DB_COUNT;
    if (s2 == stable) begin
      action = DB_IDLE;
    end else if (cnt == CNT_LAST) begin
      action = DB_ACCEPT;
    end
  end

  // NOTE: non-blocking assignments make s1 -> s2 -> stable behave as a true shift of flops;
  // blocking here would collapse the synchroniser into a single stage.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      unique case (action)
        DB_IDLE:   cnt <= '0;
        DB_ACCEPT: begin
          stable <= s2;
          cnt    <= '0;
        end
        default:   cnt <= cnt + CW'(1);
      endcase
    end
  end

  assign level = stable;
  // High during the cycle whose closing edge accepts a 0->1 change.
  assign rise  = (action == DB_ACCEPT) && s2;

endmodule

// File: rtl/input_conditioner.sv
// Synchronises and debounces board pushbuttons and switches into the LSU io_button / io_sw words.
// Define INPUT_CONDITIONER_BTN_EDGE_EN to add sticky press-event bits in io_button[31:16].
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int NUM_BTN         = 4,
  parameter int NUM_SW          = 18,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int BTN_ACTIVE_LOW  = 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NUM_BTN-1:0] btn_raw_i,
  input  logic [NUM_SW-1:0]  sw_raw_i,
  input  logic               clr_edge_i,
  output logic [31:0]        io_button,
  output logic [MAX_SW-1:0]  io_sw
);

  logic [NUM_BTN-1:0] btn_in;
  logic [NUM_BTN-1:0] btn_level;
  logic [NUM_BTN-1:0] btn_rise;
  logic [NUM_SW-1:0]  sw_level;
  logic [MAX_BTN-1:0] btn_event_word;

  // Everything downstream treats 1 as pressed, whatever the board wiring.
  assign btn_in = (BTN_ACTIVE_LOW != 0) ? ~btn_raw_i : btn_raw_i;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .raw   (btn_in[i]),
      .level (btn_level[i]),
      .rise  (btn_rise[i])
    );
  end

  for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
    logic unused_sw_rise;
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .raw   (sw_raw_i[i]),
      .level (sw_level[i]),
      .rise  (unused_sw_rise)
    );
  end

`ifdef INPUT_CONDITIONER_BTN_EDGE_EN
  logic [NUM_BTN-1:0] btn_event;

  // Clear is applied before the OR, so a press accepted on the clearing edge survives.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      btn_event <= '0;
    end else begin
      btn_event <= (clr_edge_i ? '0 : btn_event) | btn_rise;
    end
  end

  always_comb begin
    btn_event_word                = '0;
    btn_event_word[NUM_BTN-1:0]   = btn_event;
  end
`else
  logic unused_edge;
  assign unused_edge    = ^{clr_edge_i, btn_rise};
  assign btn_event_word = '0;
`endif

  always_comb begin
    io_sw                                  = '0;
    io_sw[NUM_SW-1:0]                      = sw_level;
    io_button                              = '0;
    io_button[NUM_BTN-1:0]                 = btn_level;
    io_button[BTN_EDGE_LSB +: MAX_BTN]     = btn_event_word;
  end

endmodule

// File: tb/tb_input_conditioner.sv
// Scoreboard bench for input_conditioner with DEBOUNCE_CYCLES=4 and active-low buttons.
// Stimulus pushes timed expectations; a negedge monitor pops and compares them.
module tb_input_conditioner;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [3:0]  btn_raw_i;
  logic [17:0] sw_raw_i;
  logic        clr_edge_i;
  logic [31:0] io_button;
  logic [31:0] io_sw;

  input_conditioner #(
    .NUM_BTN        (4),
    .NUM_SW         (18),
    .DEBOUNCE_CYCLES(4),
    .BTN_ACTIVE_LOW (1)
  ) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .btn_raw_i (btn_raw_i),
    .sw_raw_i  (sw_raw_i),
    .clr_edge_i(clr_edge_i),
    .io_button (io_button),
    .io_sw     (io_sw)
  );

  always #5 clk_i = ~clk_i;

  int unsigned cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    int unsigned at_cyc;
    bit          is_sw;
    logic [31:0] mask;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  localparam logic [31:0] LO = 32'h0000_FFFF;
  localparam logic [31:0] ALL = 32'hFFFF_FFFF;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic sb_push(input int unsigned c, input bit is_sw, input logic [31:0] mask,
                         input logic [31:0] val, input string name);
    exp_t e;
    e.at_cyc = c;
    e.is_sw  = is_sw;
    e.mask   = mask;
    e.val    = val;
    e.name   = name;
    sb.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  // Monitor: compares every expectation due on this cycle.
  always @(negedge clk_i) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].at_cyc == cyc) begin
        check(sb[i].name, (sb[i].is_sw ? io_sw : io_button) & sb[i].mask, sb[i].val);
        sb.delete(i);
      end
    end
`ifndef INPUT_CONDITIONER_BTN_EDGE_EN
    check("btn_hi_zero", {16'h0, io_button[31:16]}, 32'h0);
`endif
  end

  initial begin
    #200000;
    $display("FAIL watchdog: cyc=%0d expected completion", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned k;
    rst_ni     = 1'b0;
    btn_raw_i  = 4'hF;
    sw_raw_i   = 18'h3FFFF;
    clr_edge_i = 1'b0;

    // Reset with all switches already on
    step(1);
    sb_push(cyc + 1, 1'b1, ALL, 32'h0, "rst_sw");
    sb_push(cyc + 1, 1'b0, ALL, 32'h0, "rst_btn");
    step(3);
    rst_ni = 1'b1;
    k = cyc;
    sb_push(k + 5, 1'b1, ALL, 32'h0, "sw_powerup_early");
    sb_push(k + 6, 1'b1, ALL, 32'h0003_FFFF, "sw_powerup_accept");
    sb_push(k + 6, 1'b0, ALL, 32'h0, "btn_idle");
    step(10);

    // Clean press and release of button 2
    btn_raw_i[2] = 1'b0;
    k = cyc;
    sb_push(k + 5, 1'b0, LO, 32'h0, "press2_early");
    sb_push(k + 6, 1'b0, LO, 32'h4, "press2_accept");
    step(10);
    btn_raw_i[2] = 1'b1;
    k = cyc;
    sb_push(k + 5, 1'b0, LO, 32'h4, "release2_early");
    sb_push(k + 6, 1'b0, LO, 32'h0, "release2_accept");
    step(10);

    // Bounce on button 0: low 3 / high 1, twice, then held low from k+8
    k = cyc;
    for (int i = 1; i <= 13; i++) sb_push(k + i, 1'b0, LO, 32'h0, "bounce_hold");
    sb_push(k + 14, 1'b0, LO, 32'h1, "bounce_accept");
    btn_raw_i[0] = 1'b0; step(3);
    btn_raw_i[0] = 1'b1; step(1);
    btn_raw_i[0] = 1'b0; step(3);
    btn_raw_i[0] = 1'b1; step(1);
    btn_raw_i[0] = 1'b0;
    step(10);
    btn_raw_i[0] = 1'b1;
    sb_push(cyc + 6, 1'b0, LO, 32'h0, "bounce_release");
    step(10);

    // Independent switch bits changing two cycles apart
    k = cyc;
    sb_push(k + 5, 1'b1, ALL, 32'h0003_FFFF, "indep_early");
    sb_push(k + 6, 1'b1, ALL, 32'h0003_FFFE, "indep_sw0");
    sb_push(k + 7, 1'b1, ALL, 32'h0003_FFFE, "indep_gap");
    sb_push(k + 8, 1'b1, ALL, 32'h0001_FFFE, "indep_sw17");
    sw_raw_i[0] = 1'b0;
    step(2);
    sw_raw_i[17] = 1'b0;
    step(12);

    // Reset in the middle of a switch count
    k = cyc;
    sw_raw_i[5] = 1'b0;
    sb_push(k + 2, 1'b1, ALL, 32'h0001_FFFE, "midrst_before");
    sb_push(k + 4, 1'b1, ALL, 32'h0, "midrst_sw");
    sb_push(k + 4, 1'b0, ALL, 32'h0, "midrst_btn");
    step(3);
    rst_ni = 1'b0;
    step(3);
    rst_ni = 1'b1;
    k = cyc;
    sb_push(k + 5, 1'b1, ALL, 32'h0, "midrst_relatch_early");
    sb_push(k + 6, 1'b1, ALL, 32'h0001_FFDE, "midrst_relatch");
    step(10);

`ifdef INPUT_CONDITIONER_BTN_EDGE_EN
    // Press event on button 1 is sticky across release
    k = cyc;
    btn_raw_i[1] = 1'b0;
    sb_push(k + 5, 1'b0, ALL, 32'h0, "evt_press_early");
    sb_push(k + 6, 1'b0, ALL, 32'h0002_0002, "evt_press");
    step(8);
    btn_raw_i[1] = 1'b1;
    k = cyc;
    sb_push(k + 6, 1'b0, ALL, 32'h0002_0000, "evt_sticky");
    step(8);
    sb_push(cyc + 2, 1'b0, ALL, 32'h0002_0000, "evt_before_clr");
    step(2);
    clr_edge_i = 1'b1;
    sb_push(cyc + 1, 1'b0, ALL, 32'h0, "evt_cleared");
    step(1);
    clr_edge_i = 1'b0;
    step(2);

    // Press on button 3 leaves bit 19 set, to be cleared later
    btn_raw_i[3] = 1'b0;
    sb_push(cyc + 6, 1'b0, ALL, 32'h0008_0008, "evt3_press");
    step(8);
    btn_raw_i[3] = 1'b1;
    sb_push(cyc + 6, 1'b0, ALL, 32'h0008_0000, "evt3_sticky");
    step(8);

    // Button 1 accepted on the same edge as the clear: set wins, bit 19 cleared
    k = cyc;
    btn_raw_i[1] = 1'b0;
    sb_push(k + 5, 1'b0, ALL, 32'h0008_0000, "setwin_before");
    sb_push(k + 6, 1'b0, ALL, 32'h0002_0002, "setwin_edge");
    sb_push(k + 8, 1'b0, ALL, 32'h0002_0002, "setwin_hold");
    step(5);
    clr_edge_i = 1'b1;
    step(1);
    clr_edge_i = 1'b0;
    step(6);
`endif

    for (int i = 0; i < 20; i++) begin
      if (sb.size() == 0) break;
      step(1);
    end
    #1;
    foreach (sb[i]) begin
      total++;
      bad++;
      $display("FAIL %s: never compared, due cyc %0d expected %h", sb[i].name, sb[i].at_cyc,
               sb[i].val);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
- Sits directly upstream of the load/store unit's input-peripheral path.
- Synchronises and debounces raw board pushbuttons and slide switches, and drives the 32-bit io_button / io_sw words that the LSU returns on input-peripheral loads.
- Gives software glitch-free, metastability-safe values, plus optional sticky press-event bits.

Parameters:
- NUM_BTN, 4, number of pushbuttons (1..16).
- NUM_SW, 18, number of slide switches (1..32).
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a new level (≥1; 10 ms at 50 MHz).
- BTN_ACTIVE_LOW, 1, 1 = raw button reads 0 when pressed; output is always 1 = pressed.

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  asynchronous active-low reset
- btn_raw_i  in  NUM_BTN  raw pushbutton pins, asynchronous
- sw_raw_i  in  NUM_SW  raw switch pins, asynchronous
- clr_edge_i  in  1  one-cycle pulse; clears all press-event bits (only with the optional feature)
- io_button  out  32  conditioned button word to the LSU
- io_sw  out  32  conditioned switch word to the LSU

Behaviour:
- Per bit: 2-flop synchroniser (s1, s2), then debouncer holding `stable` and counter `cnt`. cnt width is $clog2(DEBOUNCE_CYCLES+1).
- Button bits are inverted before s1 when BTN_ACTIVE_LOW=1, so all internal logic is active-high.
- Each clock edge:
  - s2 == stable: cnt <= 0.
  - s2 != stable and cnt == DEBOUNCE_CYCLES-1: stable <= s2, cnt <= 0.
  - otherwise: cnt <= cnt+1.
- A bounce (s2 returns to stable) restarts the count from 0.
- Latency: a raw level first sampled at edge t appears on the output after edge t+1+DEBOUNCE_CYCLES. All outputs are registered; there is no combinational path from raw pins to outputs.
- Output mapping:
  - io_sw = {zeros, sw_stable[NUM_SW-1:0]}.
  - io_button[15:0] = {zeros, btn_stable[NUM_BTN-1:0]}.
  - io_button[31:16] = event bits (see Optional Feature), else 0.
- Reset (async assert, synchronous deassert is handled at top level):
  - s1/s2/stable = 0 (released / off); all cnt = 0; io_button = 0, io_sw = 0.
  - Reset mid-count discards the partial count.
- A level held at power-up (e.g. switch already on) is accepted after the normal latency once reset releases.
- Bits are fully independent: simultaneous changes on several bits each time out separately.
- No saturation issue: cnt never exceeds DEBOUNCE_CYCLES-1.

Optional Feature:
- Macro: INPUT_CONDITIONER_BTN_EDGE_EN.
- With macro:
  - io_button[16+i] sets on the cycle btn_stable[i] goes 0->1 and stays set until a clr_edge_i pulse.
  - clr_edge_i clears all event bits next edge.
  - A press accepted on the same edge as clr_edge_i leaves its bit set (set wins).
  - Release events are not captured. Event bits reset to 0.
- Without macro: io_button[31:16] tied 0; clr_edge_i unused; no event registers synthesised.

Decomposition:
- Package input_conditioner_pkg:
  - BTN_EDGE_LSB = 16
  - MAX_BTN = 16
  - MAX_SW = 32
  - function cnt_width(DEBOUNCE_CYCLES)
- Sub-module debounce_bit: one-bit synchroniser + counter + stable register, parameter DEBOUNCE_CYCLES. Instantiated by generate loop for every button and switch bit.
- Top level handles inversion, zero-extension and event capture.

Test Plan (DEBOUNCE_CYCLES=4, BTN_ACTIVE_LOW=1):
- Reset: hold rst_ni=0 with sw_raw_i=18'h3FFFF -> io_sw=0, io_button=0. Release -> io_sw=32'h0003FFFF after 6 edges.
- Clean press: btn_raw_i[2] 1->0 sampled at edge t -> io_button[2]=1 after edge t+5, not before. Release -> returns to 0 after same latency.
- Bounce: toggle btn_raw_i[0] low 3 cycles / high 1 cycle, repeated, then hold low -> io_button[0] stays 0 during bounce, rises exactly 6 edges after the final stable low sample.
- Independent bits: sw_raw_i[0] and sw_raw_i[17] change 2 cycles apart -> io_sw bits update 2 cycles apart, each with 6-edge latency.
- Reset mid-count: assert rst_ni after 2 stable cycles of a switch change -> count discarded, io_sw=0, full latency restarts after release.
- INPUT_CONDITIONER_BTN_EDGE_EN:
  - Press btn 1 -> io_button[17]=1 and remains after release.
  - clr_edge_i pulse -> io_button[17]=0.
  - Press accepted on same edge as clr_edge_i -> bit stays 1.
  - Without macro: io_button[31:16]==0 throughout.
